// File: rtl/t1_sim_sequencer_if.sv
// ----------------------------------------------------------------------------
// t1_sim_sequencer_if
// Bundles the sim-control bus between the DPI shim / testbench (master) and
// the t1_sim_sequencer block (slave).
//
// Master drives : st_valid_i, st_code_i, idle_i, global_timeout_i,
//                 drain_timeout_i (+ dump_start_i, dump_end_i)
// Slave drives  : core_reset_o, init_flag_o, cycle_o, quit_mask_o, finish_o,
//                 fault_o, fault_cause_o, fault_ch_o (+ dump_on_o)
//
// Optional feature macro: T1_SIMSEQ_DUMP_WINDOW_EN adds the dump-window
// signals shown in parentheses above.
// ----------------------------------------------------------------------------
interface t1_sim_sequencer_if #(
   parameter int NUM_CH = 1,
   parameter int CNT_W  = 64
);
   localparam int CH_W = $clog2(NUM_CH) + 1;

   logic [NUM_CH-1:0]   st_valid_i;
   logic [8*NUM_CH-1:0] st_code_i;
   logic [NUM_CH-1:0]   idle_i;
   logic [CNT_W-1:0]    global_timeout_i;
   logic [CNT_W-1:0]    drain_timeout_i;

   logic                core_reset_o;
   logic                init_flag_o;
   logic [CNT_W-1:0]    cycle_o;
   logic [NUM_CH-1:0]   quit_mask_o;
   logic                finish_o;
   logic                fault_o;
   logic [1:0]          fault_cause_o;
   logic [CH_W-1:0]     fault_ch_o;

`ifdef T1_SIMSEQ_DUMP_WINDOW_EN
   logic [CNT_W-1:0]    dump_start_i;
   logic [CNT_W-1:0]    dump_end_i;
   logic                dump_on_o;

   modport master (
      output st_valid_i, st_code_i, idle_i, global_timeout_i, drain_timeout_i,
             dump_start_i, dump_end_i,
      input  core_reset_o, init_flag_o, cycle_o, quit_mask_o, finish_o,
             fault_o, fault_cause_o, fault_ch_o, dump_on_o
   );

   modport slave (
      input  st_valid_i, st_code_i, idle_i, global_timeout_i, drain_timeout_i,
             dump_start_i, dump_end_i,
      output core_reset_o, init_flag_o, cycle_o, quit_mask_o, finish_o,
             fault_o, fault_cause_o, fault_ch_o, dump_on_o
   );
`else
   modport master (
      output st_valid_i, st_code_i, idle_i, global_timeout_i, drain_timeout_i,
      input  core_reset_o, init_flag_o, cycle_o, quit_mask_o, finish_o,
             fault_o, fault_cause_o, fault_ch_o
   );

   modport slave (
      input  st_valid_i, st_code_i, idle_i, global_timeout_i, drain_timeout_i,
      output core_reset_o, init_flag_o, cycle_o, quit_mask_o, finish_o,
             fault_o, fault_cause_o, fault_ch_o
   );
`endif

endinterface

// File: rtl/t1_sim_sequencer.sv
// ----------------------------------------------------------------------------
// t1_sim_sequencer
// Multi-channel simulation sequencer. After reset_n release it holds the DUT
// in init/reset for a fixed number of edges, then watches each channel's
// cosim watchdog code. It ends the run with a one-cycle finish_o pulse once
// every channel has quit and its DUT side is idle. It ends with a one-cycle
// fault_o pulse on a watchdog error, a drain (idle) timeout or a global
// cycle timeout.
//
// Ports
//   clock    : simulation clock
//   reset_n  : asynchronous active-low reset
//   bus      : t1_sim_sequencer_if.slave
//                st_valid_i/st_code_i/idle_i : per-channel status in
//                global_timeout_i            : fault when cycle_o hits it (0 off)
//                drain_timeout_i             : max cycles from all-quit to all-idle
//                core_reset_o/init_flag_o    : DUT reset and init flag
//                cycle_o                     : running cycle count
//                quit_mask_o                 : sticky per-channel quit
//                finish_o/fault_o            : one-cycle end pulses
//                fault_cause_o/fault_ch_o    : latched fault cause / channel
//
// Optional feature macro: T1_SIMSEQ_DUMP_WINDOW_EN adds a waveform dump
// window (dump_start_i, dump_end_i -> dump_on_o).
//
// Timing notes: cycle_o counts edges since reset_n release, so after edge k
// it reads k. The entry edge into DONE/FAULT still advances cycle_o, and the
// end pulse appears together with that final count. The global timeout
// compares the count that will be visible after the edge. As a result,
// fault_o and cycle_o == global_timeout_i appear together.
// ----------------------------------------------------------------------------
module t1_sim_sequencer #(
   parameter int NUM_CH       = 1,
   parameter int CNT_W        = 64,
   parameter int INIT_CYCLES  = 1,
   parameter int RESET_CYCLES = 5
) (
   input  logic                clock,
   input  logic                reset_n,
   t1_sim_sequencer_if.slave   bus
);

   localparam int               CH_W      = $clog2(NUM_CH) + 1;
   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] INIT_END  = CNT_W'(INIT_CYCLES);
   localparam logic [CNT_W-1:0] RESET_END = CNT_W'(RESET_CYCLES);

   localparam logic [1:0] CAUSE_WDOG  = 2'd1;
   localparam logic [1:0] CAUSE_IDLE  = 2'd2;
   localparam logic [1:0] CAUSE_GLOBAL = 2'd3;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_RESET = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4,
      ST_FAULT = 3'd5
   } state_t;

   // Index of the lowest set bit (0 when none is set).
   function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] vec);
      logic [CH_W-1:0] idx;
      idx = '0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (vec[c]) begin
            idx = CH_W'(c);
         end
      end
      return idx;
   endfunction

   // Registered state and outputs
   state_t            state_r;
   logic              core_reset_r;
   logic              init_flag_r;
   logic [CNT_W-1:0]  cycle_r;
   logic [CNT_W-1:0]  drain_r;
   logic [NUM_CH-1:0] quit_r;
   logic              finish_r;
   logic              fault_r;
   logic [1:0]        cause_r;
   logic [CH_W-1:0]   fault_ch_r;

   // Decoded per-cycle status
   logic [NUM_CH-1:0] active_s;
   logic [NUM_CH-1:0] err_s;
   logic [NUM_CH-1:0] quit_s;
   logic              err_any_s;
   logic [CH_W-1:0]   err_ch_s;
   logic [NUM_CH-1:0] mask_nxt_s;
   logic              all_quit_s;
   logic              all_idle_s;
   logic [CNT_W-1:0]  cycle_nxt_s;
   logic [CNT_W-1:0]  drain_nxt_s;
   logic              gt_hit_s;
   logic              drain_to_s;

   // Decode watchdog codes of channels that have not quit yet, plus the
   // timeout compares against the post-edge counter values.
   always_comb begin
      active_s = bus.st_valid_i & ~quit_r;
      err_s    = '0;
      quit_s   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (active_s[c]) begin
            if (bus.st_code_i[8*c +: 8] == 8'd255) begin
               quit_s[c] = 1'b1;
            end else if (bus.st_code_i[8*c +: 8] != 8'd0) begin
               err_s[c] = 1'b1;
            end else begin
               quit_s[c] = 1'b0;
            end
         end else begin
            quit_s[c] = 1'b0;
         end
      end
      err_any_s   = |err_s;
      err_ch_s    = lowest_set(err_s);
      mask_nxt_s  = quit_r | quit_s;
      all_quit_s  = &mask_nxt_s;
      all_idle_s  = &bus.idle_i;
      cycle_nxt_s = cycle_r + CNT_ONE;
      drain_nxt_s = drain_r + CNT_ONE;
      gt_hit_s    = (bus.global_timeout_i != CNT_ZERO) &&
                    (cycle_nxt_s == bus.global_timeout_i);
      drain_to_s  = (drain_nxt_s > bus.drain_timeout_i);
   end

   // Sequencer FSM with all registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= ST_INIT;
         core_reset_r <= 1'b1;
         init_flag_r  <= 1'b1;
         cycle_r      <= CNT_ZERO;
         drain_r      <= CNT_ZERO;
         quit_r       <= '0;
         finish_r     <= 1'b0;
         fault_r      <= 1'b0;
         cause_r      <= 2'd0;
         fault_ch_r   <= '0;
      end else begin
         finish_r <= 1'b0;
         fault_r  <= 1'b0;
         case (state_r)
            ST_INIT: begin
               cycle_r <= cycle_nxt_s;
               if (cycle_nxt_s == INIT_END) begin
                  init_flag_r <= 1'b0;
                  // Equal init and reset lengths skip the RESET state.
                  if (cycle_nxt_s == RESET_END) begin
                     core_reset_r <= 1'b0;
                     state_r      <= ST_RUN;
                  end else begin
                     state_r <= ST_RESET;
                  end
               end
            end
            ST_RESET: begin
               cycle_r <= cycle_nxt_s;
               if (cycle_nxt_s == RESET_END) begin
                  core_reset_r <= 1'b0;
                  state_r      <= ST_RUN;
               end
            end
            ST_RUN: begin
               cycle_r <= cycle_nxt_s;
               if (err_any_s) begin
                  // A watchdog error beats quits, done and timeouts, and
                  // the quit mask is left as it was before this cycle.
                  state_r    <= ST_FAULT;
                  fault_r    <= 1'b1;
                  cause_r    <= CAUSE_WDOG;
                  fault_ch_r <= err_ch_s;
               end else begin
                  quit_r <= mask_nxt_s;
                  if (all_quit_s && all_idle_s) begin
                     state_r  <= ST_DONE;
                     finish_r <= 1'b1;
                  end else if (gt_hit_s) begin
                     state_r <= ST_FAULT;
                     fault_r <= 1'b1;
                     cause_r <= CAUSE_GLOBAL;
                  end else if (all_quit_s) begin
                     state_r <= ST_DRAIN;
                     drain_r <= CNT_ZERO;
                  end
               end
            end
            ST_DRAIN: begin
               cycle_r <= cycle_nxt_s;
               if (all_idle_s) begin
                  state_r  <= ST_DONE;
                  finish_r <= 1'b1;
               end else if (drain_to_s) begin
                  state_r <= ST_FAULT;
                  fault_r <= 1'b1;
                  cause_r <= CAUSE_IDLE;
               end else if (gt_hit_s) begin
                  state_r <= ST_FAULT;
                  fault_r <= 1'b1;
                  cause_r <= CAUSE_GLOBAL;
               end else begin
                  drain_r <= drain_nxt_s;
               end
            end
            ST_DONE, ST_FAULT: begin
               // Terminal: counters and latched results hold until reset.
               state_r <= state_r;
            end
            default: begin
               // Unreachable encoding: park in FAULT without a pulse.
               state_r <= ST_FAULT;
            end
         endcase
      end
   end

   assign bus.core_reset_o  = core_reset_r;
   assign bus.init_flag_o   = init_flag_r;
   assign bus.cycle_o       = cycle_r;
   assign bus.quit_mask_o   = quit_r;
   assign bus.finish_o      = finish_r;
   assign bus.fault_o       = fault_r;
   assign bus.fault_cause_o = cause_r;
   assign bus.fault_ch_o    = fault_ch_r;

`ifdef T1_SIMSEQ_DUMP_WINDOW_EN
   logic dump_r;
   logic term_s;
   logic to_run_s;
   logic live_s;
   logic dump_set_s;
   logic dump_clr_s;
   logic dump_upd_s;

   // Mirror the FSM's terminal-entry conditions and compute the next dump
   // window state from the post-edge cycle count.
   always_comb begin
      case (state_r)
         ST_RUN:   term_s = err_any_s | (all_quit_s & all_idle_s) | gt_hit_s;
         ST_DRAIN: term_s = all_idle_s | drain_to_s | gt_hit_s;
         ST_DONE:  term_s = 1'b1;
         ST_FAULT: term_s = 1'b1;
         default:  term_s = 1'b0;
      endcase
      to_run_s = ((state_r == ST_INIT) || (state_r == ST_RESET)) &&
                 (cycle_nxt_s == RESET_END);
      live_s   = (state_r == ST_RUN) || (state_r == ST_DRAIN) || to_run_s;
      if (bus.dump_start_i == CNT_ZERO) begin
         dump_set_s = to_run_s;
      end else begin
         dump_set_s = live_s && (cycle_nxt_s == bus.dump_start_i);
      end
      dump_clr_s = (bus.dump_end_i != CNT_ZERO) && (cycle_nxt_s == bus.dump_end_i);
      if (dump_clr_s) begin
         dump_upd_s = 1'b0;
      end else if (dump_set_s) begin
         dump_upd_s = 1'b1;
      end else begin
         dump_upd_s = dump_r;
      end
   end

   // Dump window register; forced off on entry to and while in DONE/FAULT.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dump_r <= 1'b0;
      end else if (term_s) begin
         dump_r <= 1'b0;
      end else begin
         dump_r <= dump_upd_s;
      end
   end

   assign bus.dump_on_o = dump_r;
`endif

endmodule

// File: tb/tb_t1_sim_sequencer.sv
module tb_t1_sim_sequencer;

   localparam int NUM_CH    = 2;
   localparam int CNT_W     = 32;
   localparam int INIT_CYC  = 1;
   localparam int RESET_CYC = 5;
   localparam int MAXC      = 10200;

   logic clock = 1'b0;
   logic reset_n = 1'b0;

   always #5 clock = ~clock;

   t1_sim_sequencer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   t1_sim_sequencer #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W),
      .INIT_CYCLES(INIT_CYC), .RESET_CYCLES(RESET_CYC)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus)
   );

   // kind: 1 = finish pulse, 2 = fault pulse
   typedef struct {
      int         kind;
      int         cyc;
      int         cause;
      int         ch;
      logic [1:0] mask;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int checks = 0;
   int errors = 0;

   // Stimulus tables indexed by the cycle_o value at which they are presented.
   logic [1:0] sv_a [MAXC];
   logic [7:0] c0_a [MAXC];
   logic [7:0] c1_a [MAXC];
   logic [1:0] id_a [MAXC];
   int len, gt, dt, abort_at;

   // Reference model results
   int m_kind, m_cyc, m_cause, m_ch;
   logic [1:0] m_mask;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic clear_stim();
      for (int k = 0; k < MAXC; k++) begin
         sv_a[k] = 2'b00; c0_a[k] = 8'd0; c1_a[k] = 8'd0; id_a[k] = 2'b00;
      end
      gt = 0; dt = 0; abort_at = -1; len = 100;
   endtask

   // Walks the run cycle by cycle from the first RUN cycle, applying the
   // end-of-run rules directly: error > done > timeouts; drain timeout once
   // the number of cycles spent draining exceeds dt.
   task automatic run_model();
      logic [1:0] mask, errs, quits;
      logic [7:0] code;
      int dstart;
      mask = 2'b00; dstart = -1;
      m_kind = 0; m_cyc = -1; m_cause = 0; m_ch = 0; m_mask = 2'b00;
      for (int c = RESET_CYC; c < len; c++) begin
         if (dstart < 0) begin
            errs = 2'b00; quits = 2'b00;
            for (int ch = 0; ch < NUM_CH; ch++) begin
               code = (ch == 0) ? c0_a[c] : c1_a[c];
               if (sv_a[c][ch] && !mask[ch]) begin
                  if (code == 8'd255) quits[ch] = 1'b1;
                  else if (code != 8'd0) errs[ch] = 1'b1;
               end
            end
            if (errs != 2'b00) begin
               m_kind = 2; m_cyc = c + 1; m_cause = 1; m_ch = errs[0] ? 0 : 1; m_mask = mask;
               return;
            end
            mask = mask | quits;
            if (mask == 2'b11 && id_a[c] == 2'b11) begin
               m_kind = 1; m_cyc = c + 1; m_mask = mask; return;
            end
            if (gt != 0 && c + 1 == gt) begin
               m_kind = 2; m_cyc = c + 1; m_cause = 3; m_mask = mask; return;
            end
            if (mask == 2'b11) dstart = c + 1;
         end else begin
            if (id_a[c] == 2'b11) begin
               m_kind = 1; m_cyc = c + 1; m_mask = mask; return;
            end
            if (c - dstart + 1 > dt) begin
               m_kind = 2; m_cyc = c + 1; m_cause = 2; m_mask = mask; return;
            end
            if (gt != 0 && c + 1 == gt) begin
               m_kind = 2; m_cyc = c + 1; m_cause = 3; m_mask = mask; return;
            end
         end
      end
   endtask

   task automatic drive(input int k);
      if (k < len) begin
         bus.st_valid_i = sv_a[k];
         bus.st_code_i  = {c1_a[k], c0_a[k]};
         bus.idle_i     = id_a[k];
      end else begin
         bus.st_valid_i = 2'b00;
         bus.st_code_i  = 16'd0;
         bus.idle_i     = 2'b00;
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_rst_core_reset"}, bus.core_reset_o, 1);
      chk({tag, "_rst_init_flag"},  bus.init_flag_o, 1);
      chk({tag, "_rst_cycle"},      bus.cycle_o, 0);
      chk({tag, "_rst_quit_mask"},  bus.quit_mask_o, 0);
      chk({tag, "_rst_finish"},     bus.finish_o, 0);
      chk({tag, "_rst_fault"},      bus.fault_o, 0);
      chk({tag, "_rst_cause"},      bus.fault_cause_o, 0);
      chk({tag, "_rst_fault_ch"},   bus.fault_ch_o, 0);
   endtask

   task automatic run_scenario(input string tag);
      exp_t e;
      int endk, expc;
      bit aborted;
      aborted = 1'b0;
      run_model();
      if (m_kind != 0 && (abort_at < 0 || m_cyc < abort_at)) begin
         e.kind = m_kind; e.cyc = m_cyc; e.cause = m_cause; e.ch = m_ch; e.mask = m_mask;
         exp_q.push_back(e);
      end
      bus.global_timeout_i = gt;
      bus.drain_timeout_i  = dt;
      reset_n = 1'b0;
      drive(len);
      repeat (3) @(posedge clock);
      #1;
      check_reset_values(tag);
      reset_n = 1'b1;
      endk = len;
      if (m_kind != 0 && m_cyc + 3 < len) endk = m_cyc + 3;
      for (int k = 0; k <= endk; k++) begin
         drive(k);
         if (abort_at >= 0 && k == abort_at) begin
            reset_n = 1'b0;
            #1;
            check_reset_values({tag, "_abort"});
            aborted = 1'b1;
            break;
         end
         expc = (m_kind != 0 && k > m_cyc) ? m_cyc : k;
         chk({tag, "_cycle"},      bus.cycle_o, expc);
         chk({tag, "_init_flag"},  bus.init_flag_o, (k < INIT_CYC) ? 1 : 0);
         chk({tag, "_core_reset"}, bus.core_reset_o, (k < RESET_CYC) ? 1 : 0);
         @(posedge clock);
         #1;
      end
      if (!aborted && m_kind != 0) begin
         chk({tag, "_hold_cause"},   bus.fault_cause_o, m_cause);
         chk({tag, "_hold_fault_ch"}, bus.fault_ch_o, m_ch);
      end
      chk({tag, "_pending_pulses"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic random_stim();
      int r;
      len = 300;
      gt  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(10, 320));
      dt  = $urandom_range(0, 15);
      for (int k = 0; k < len; k++) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            sv_a[k][ch] = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 99);
            if (ch == 0) c0_a[k] = (r < 75) ? 8'd0 : (r < 99) ? 8'd255 : 8'($urandom_range(1, 254));
            else         c1_a[k] = (r < 75) ? 8'd0 : (r < 99) ? 8'd255 : 8'($urandom_range(1, 254));
            id_a[k][ch] = ($urandom_range(0, 3) != 0);
         end
      end
   endtask

   // Scoreboard monitor: samples on the falling edge, away from the active edge.
   always @(negedge clock) begin
      if (reset_n && (bus.finish_o || bus.fault_o)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: finish=%0b fault=%0b cycle=%0d, expected no pulse",
                     bus.finish_o, bus.fault_o, bus.cycle_o);
         end else begin
            mon_e = exp_q.pop_front();
            chk("pulse_finish",   bus.finish_o, (mon_e.kind == 1) ? 1 : 0);
            chk("pulse_fault",    bus.fault_o, (mon_e.kind == 2) ? 1 : 0);
            chk("pulse_cycle",    bus.cycle_o, mon_e.cyc);
            chk("pulse_cause",    bus.fault_cause_o, mon_e.cause);
            chk("pulse_fault_ch", bus.fault_ch_o, mon_e.ch);
            chk("pulse_quit_mask", bus.quit_mask_o, mon_e.mask);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_watchdog: simulation time limit reached, expected completion");
      $fatal(1, "time limit");
   end

   initial begin
      bus.st_valid_i = 2'b00;
      bus.st_code_i  = 16'd0;
      bus.idle_i     = 2'b00;
      bus.global_timeout_i = 32'd0;
      bus.drain_timeout_i  = 32'd0;

      // Clean end: ch0 quits at 20, ch1 at 30, all idle
      clear_stim(); len = 80; dt = 50;
      for (int k = 0; k < len; k++) id_a[k] = 2'b11;
      sv_a[20] = 2'b01; c0_a[20] = 8'd255;
      sv_a[30] = 2'b10; c1_a[30] = 8'd255;
      run_scenario("clean");

      // Drain timeout: all quit, never idle
      clear_stim(); len = 80; dt = 10;
      sv_a[39] = 2'b11; c0_a[39] = 8'd255; c1_a[39] = 8'd255;
      run_scenario("drain_to");

      // Drain ends by idle on the same cycle the timeout would fire
      clear_stim(); len = 80; dt = 10;
      sv_a[39] = 2'b11; c0_a[39] = 8'd255; c1_a[39] = 8'd255;
      for (int k = 50; k < len; k++) id_a[k] = 2'b11;
      run_scenario("drain_idle");

      // Error beats quit in the same cycle
      clear_stim(); len = 60;
      sv_a[25] = 2'b11; c0_a[25] = 8'd255; c1_a[25] = 8'd7;
      run_scenario("err_prio");

      // Global timeout
      clear_stim(); len = 150; gt = 100;
      for (int k = 0; k < len; k++) id_a[k] = 2'($urandom_range(0, 3));
      run_scenario("global_to");

      // Done beats global timeout in the same cycle
      clear_stim(); len = 80; gt = 50;
      for (int k = 0; k < len; k++) id_a[k] = 2'b11;
      sv_a[49] = 2'b11; c0_a[49] = 8'd255; c1_a[49] = 8'd255;
      run_scenario("done_vs_gt");

      // Error beats global timeout in the same cycle
      clear_stim(); len = 80; gt = 50;
      sv_a[49] = 2'b01; c0_a[49] = 8'd3;
      run_scenario("err_vs_gt");

      // Codes from a quit channel are ignored
      clear_stim(); len = 80;
      for (int k = 0; k < len; k++) id_a[k] = 2'b11;
      sv_a[20] = 2'b01; c0_a[20] = 8'd255;
      sv_a[22] = 2'b01; c0_a[22] = 8'd9;
      sv_a[30] = 2'b10; c1_a[30] = 8'd255;
      run_scenario("quit_ignore");

      // Reset asserted during DRAIN
      clear_stim(); len = 200; dt = 100; abort_at = 60;
      sv_a[39] = 2'b11; c0_a[39] = 8'd255; c1_a[39] = 8'd255;
      run_scenario("mid_reset");

      // Global timeout disabled: run well past 10000 cycles with no end
      clear_stim(); len = 10050;
      for (int k = 0; k < len; k++) begin
         sv_a[k] = 2'($urandom_range(0, 3));
         id_a[k] = 2'($urandom_range(0, 3));
      end
      run_scenario("no_gt");

      // Randomised runs
      for (int i = 0; i < 20; i++) begin
         clear_stim();
         random_stim();
         run_scenario($sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
